// File: rtl/pong_ball_ctrl_pkg.sv
// Shared types and helpers for the Pong ball engine: FSM encoding, screen
// defaults and the speed saturation step.
package pong_ball_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SERVE  = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2
    } state_t;

    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;
    localparam int POS_W        = 10;
    localparam int NXT_W        = 11;
    localparam int SPD_W        = 8;

    function automatic logic [SPD_W-1:0] sat_inc(input logic [SPD_W-1:0] s,
                                                 input logic [SPD_W-1:0] lim);
        return (s < lim) ? s + 1'b1 : s;
    endfunction

endpackage

// File: rtl/pong_ball_ctrl_if.sv
// Bundle between the ball engine and its neighbours: paddle boxes and scan
// position in, ball position, pixel flag and score/serve status out.
interface pong_ball_ctrl_if;
    logic [9:0] pad1_t, pad1_b, pad1_l, pad1_r;
    logic [9:0] pad2_t, pad2_b, pad2_l, pad2_r;
    logic [9:0] x, y;
    logic       ball_on;
    logic [9:0] ball_x, ball_y;
    logic       score1, score2;
    logic       serving;

    modport master (
        output pad1_t, pad1_b, pad1_l, pad1_r,
        output pad2_t, pad2_b, pad2_l, pad2_r,
        output x, y,
        input  ball_on, ball_x, ball_y, score1, score2, serving
    );

    modport slave (
        input  pad1_t, pad1_b, pad1_l, pad1_r,
        input  pad2_t, pad2_b, pad2_l, pad2_r,
        input  x, y,
        output ball_on, ball_x, ball_y, score1, score2, serving
    );
endinterface

// File: rtl/pong_ball_ctrl_render.sv
// Pixel-layer test: is the current scan position inside the ball?
// Zero-latency combinational; circular or square footprint.
module pong_ball_ctrl_render #(
    parameter int BALL_SIZE = 10,
    parameter bit ROUND     = 1'b1
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       ball_on
);
    localparam int          HALF   = BALL_SIZE / 2;
    localparam logic [11:0] SIZE_M1 = 12'(BALL_SIZE - 1);
    localparam logic [20:0] R_SQ   = 21'(HALF * HALF);
    localparam logic signed [11:0] HALF_S = 12'(HALF);

    logic              in_box;
    logic signed [11:0] dx, dy;
    logic [9:0]        adx, ady;
    logic [19:0]       dx_sq, dy_sq;
    logic [20:0]       dist_sq;

    always_comb begin
        in_box = ({2'b00, x} >= {2'b00, ball_x}) && ({2'b00, x} <= {2'b00, ball_x} + SIZE_M1) &&
                 ({2'b00, y} >= {2'b00, ball_y}) && ({2'b00, y} <= {2'b00, ball_y} + SIZE_M1);
        // Centre sits between pixels for an even size; offsets are taken from ball_x+HALF.
        dx      = $signed({2'b00, x}) - $signed({2'b00, ball_x}) - HALF_S;
        dy      = $signed({2'b00, y}) - $signed({2'b00, ball_y}) - HALF_S;
        adx     = dx[11] ? 10'(-dx) : 10'(dx);
        ady     = dy[11] ? 10'(-dy) : 10'(dy);
        dx_sq   = 20'(adx) * 20'(adx);
        dy_sq   = 20'(ady) * 20'(ady);
        dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
        ball_on = ROUND ? (in_box && (dist_sq <= R_SQ)) : in_box;
    end
endmodule

// File: rtl/pong_ball_ctrl.sv
// Ball engine: serve/play/scored FSM, per-frame motion with wall and paddle
// bounces, speed-up after repeated hits, and one-clock score pulses.
module pong_ball_ctrl
    import pong_ball_ctrl_pkg::*;
#(
    parameter int X_MAX         = SCREEN_X_MAX,
    parameter int Y_MAX         = SCREEN_Y_MAX,
    parameter int BALL_SIZE     = 10,
    parameter bit ROUND         = 1'b1,
    parameter int SPEED_INIT    = 1,
    parameter int SPEED_MAX     = 4,
    parameter int HITS_PER_STEP = 4,
    parameter int SERVE_FRAMES  = 60,
    parameter int TICK_Y        = 481
) (
    input  logic            clk,
    input  logic            reset,
    pong_ball_ctrl_if.slave bus
);
    localparam int FC_W = $clog2(SERVE_FRAMES + 1);
    localparam int HC_W = $clog2(HITS_PER_STEP + 1);

    localparam logic [9:0]       X_C      = 10'((X_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [9:0]       Y_C      = 10'((Y_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(SERVE_FRAMES - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HITS_PER_STEP - 1);
    localparam logic [SPD_W-1:0] SPD_INIT = SPD_W'(SPEED_INIT);
    localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(SPEED_MAX);

    localparam logic signed [NXT_W-1:0] ZERO_S = '0;
    localparam logic signed [NXT_W-1:0] ONE_S  = NXT_W'(1);
    localparam logic signed [NXT_W-1:0] BS_S   = NXT_W'(BALL_SIZE);
    localparam logic signed [NXT_W-1:0] BS_M1  = NXT_W'(BALL_SIZE - 1);
    localparam logic signed [NXT_W-1:0] XMAX_S = NXT_W'(X_MAX);
    localparam logic signed [NXT_W-1:0] YMAX_S = NXT_W'(Y_MAX);
    localparam logic signed [NXT_W-1:0] Y_BOT  = NXT_W'(Y_MAX - BALL_SIZE + 1);

    state_t           state;
    logic [9:0]       ball_x, ball_y;
    logic             dir_x, dir_y;
    logic [SPD_W-1:0] speed;
    logic [HC_W-1:0]  hit_cnt;
    logic [FC_W-1:0]  frame_cnt;
    logic             score1, score2;

    logic                     tick;
    logic signed [NXT_W-1:0]  spd_s, x_cur, y_cur, x_next, y_next, y_new;
    logic signed [NXT_W-1:0]  p1t, p1b, p1l, p1r, p2t, p2b, p2l, p2r;
    logic                     top_hit, bot_hit, dir_y_new;
    logic                     ovl1, ovl2, hit1, hit2, hit, out_left, out_right;
    logic [9:0]               x_hit;

    assign tick = (bus.y == 10'(TICK_Y)) && (bus.x == 10'd0);

    // Motion and collision for the next frame, all in 11-bit signed so nothing wraps.
    always_comb begin
        spd_s  = $signed(NXT_W'(speed));
        x_cur  = $signed({1'b0, ball_x});
        y_cur  = $signed({1'b0, ball_y});
        x_next = dir_x ? x_cur + spd_s : x_cur - spd_s;
        y_next = dir_y ? y_cur + spd_s : y_cur - spd_s;

        top_hit   = (y_next <= ZERO_S);
        bot_hit   = (y_next + BS_M1 >= YMAX_S);
        y_new     = top_hit ? ZERO_S : (bot_hit ? Y_BOT : y_next);
        dir_y_new = top_hit ? 1'b1 : (bot_hit ? 1'b0 : dir_y);

        p1t = $signed({1'b0, bus.pad1_t});
        p1b = $signed({1'b0, bus.pad1_b});
        p1l = $signed({1'b0, bus.pad1_l});
        p1r = $signed({1'b0, bus.pad1_r});
        p2t = $signed({1'b0, bus.pad2_t});
        p2b = $signed({1'b0, bus.pad2_b});
        p2l = $signed({1'b0, bus.pad2_l});
        p2r = $signed({1'b0, bus.pad2_r});

        ovl1 = (x_next <= p1r) && (x_next + BS_M1 >= p1l) && (y_new <= p1b) && (y_new + BS_M1 >= p1t);
        ovl2 = (x_next <= p2r) && (x_next + BS_M1 >= p2l) && (y_new <= p2b) && (y_new + BS_M1 >= p2t);
        // Only a paddle the ball is heading into can bounce it, so it never sticks.
        hit1 = !dir_x && ovl1;
        hit2 = dir_x && ovl2;
        hit  = hit1 || hit2;
        x_hit = hit1 ? 10'(p1r + ONE_S) : 10'(p2l - BS_S);

        out_left  = (x_next < ZERO_S);
        out_right = (x_next + BS_M1 > XMAX_S);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SERVE;
            ball_x    <= X_C;
            ball_y    <= Y_C;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            speed     <= SPD_INIT;
            hit_cnt   <= '0;
            frame_cnt <= '0;
            score1    <= 1'b0;
            score2    <= 1'b0;
        end else begin
            score1 <= 1'b0;
            score2 <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SERVE: begin
                        if (frame_cnt == FC_LAST) begin
                            state     <= ST_PLAY;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (hit) begin
                            ball_x <= x_hit;
                            ball_y <= y_new[9:0];
                            dir_x  <= ~dir_x;
                            dir_y  <= dir_y_new;
                            if (hit_cnt == HC_LAST) begin
                                hit_cnt <= '0;
                                speed   <= sat_inc(speed, SPD_MAX);
                            end else begin
                                hit_cnt <= hit_cnt + 1'b1;
                            end
                        end else if (out_left) begin
                            score2 <= 1'b1;
                            dir_x  <= 1'b0;
                            state  <= ST_SCORED;
                        end else if (out_right) begin
                            score1 <= 1'b1;
                            dir_x  <= 1'b1;
                            state  <= ST_SCORED;
                        end else begin
                            ball_x <= x_next[9:0];
                            ball_y <= y_new[9:0];
                            dir_y  <= dir_y_new;
                        end
                    end
                    ST_SCORED: begin
                        state     <= ST_SERVE;
                        ball_x    <= X_C;
                        ball_y    <= Y_C;
                        speed     <= SPD_INIT;
                        hit_cnt   <= '0;
                        frame_cnt <= '0;
                        dir_y     <= ~dir_y;
                    end
                    default: state <= ST_SERVE;
                endcase
            end
        end
    end

    assign bus.ball_x  = ball_x;
    assign bus.ball_y  = ball_y;
    assign bus.score1  = score1;
    assign bus.score2  = score2;
    assign bus.serving = (state == ST_SERVE);

    pong_ball_ctrl_render #(
        .BALL_SIZE (BALL_SIZE),
        .ROUND     (ROUND)
    ) u_render (
        .x       (bus.x),
        .y       (bus.y),
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .ball_on (bus.ball_on)
    );
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for the ball engine: serve timing, motion, walls, paddle
// bounces and speed-up, scoring, mid-flight reset and both ball shapes.
module tb_pong_ball_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pong_ball_ctrl_if bus_r ();
    pong_ball_ctrl_if bus_s ();

    pong_ball_ctrl #(.ROUND(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_r.slave)
    );

    pong_ball_ctrl #(.ROUND(1'b0)) dut_sq (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    assign bus_s.x      = bus_r.x;
    assign bus_s.y      = bus_r.y;
    assign bus_s.pad1_t = bus_r.pad1_t;
    assign bus_s.pad1_b = bus_r.pad1_b;
    assign bus_s.pad1_l = bus_r.pad1_l;
    assign bus_s.pad1_r = bus_r.pad1_r;
    assign bus_s.pad2_t = bus_r.pad2_t;
    assign bus_s.pad2_b = bus_r.pad2_b;
    assign bus_s.pad2_l = bus_r.pad2_l;
    assign bus_s.pad2_r = bus_r.pad2_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus_r.x = 10'd0;
        bus_r.y = 10'd481;
        @(negedge clk);
        bus_r.y = 10'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic park();
        bus_r.pad1_t = 10'd1000; bus_r.pad1_b = 10'd1010;
        bus_r.pad1_l = 10'd0;    bus_r.pad1_r = 10'd1023;
        bus_r.pad2_t = 10'd1000; bus_r.pad2_b = 10'd1010;
        bus_r.pad2_l = 10'd0;    bus_r.pad2_r = 10'd1023;
    endtask

    task automatic set_pads(input int p1l, input int p1r, input int p2l, input int p2r);
        bus_r.pad1_t = 10'd0; bus_r.pad1_b = 10'd479;
        bus_r.pad1_l = 10'(p1l); bus_r.pad1_r = 10'(p1r);
        bus_r.pad2_t = 10'd0; bus_r.pad2_b = 10'd479;
        bus_r.pad2_l = 10'(p2l); bus_r.pad2_r = 10'(p2r);
    endtask

    task automatic pix(input int px, input int py, input logic exp_r, input logic exp_s, input string tag);
        @(negedge clk);
        bus_r.x = 10'(px);
        bus_r.y = 10'(py);
        #1;
        chk({tag, "_round"}, bus_r.ball_on, exp_r);
        chk({tag, "_square"}, bus_s.ball_on, exp_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_r.x = 10'd0;
        bus_r.y = 10'd0;
        park();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_serving", bus_r.serving, 1);
        chk("rst_ball_x", bus_r.ball_x, 315);
        chk("rst_ball_y", bus_r.ball_y, 235);
        chk("rst_score1", bus_r.score1, 0);
        chk("rst_score2", bus_r.score2, 0);
        chk("rst_speed", dut.speed, 1);

        // Pixel layer around ball at (315,235), centre (320,240)
        pix(315, 235, 1'b0, 1'b1, "pix_corner");
        pix(320, 240, 1'b1, 1'b1, "pix_centre");
        pix(315, 240, 1'b1, 1'b1, "pix_left_edge");
        pix(324, 235, 1'b0, 1'b1, "pix_tr_corner");
        pix(325, 240, 1'b0, 1'b0, "pix_outside");
        @(negedge clk);
        bus_r.x = 10'd0;
        bus_r.y = 10'd0;

        // Serve hold
        ticks(59);
        chk("serve59_serving", bus_r.serving, 1);
        tick();
        chk("serve60_serving", bus_r.serving, 0);
        chk("serve60_x", bus_r.ball_x, 315);
        chk("serve60_y", bus_r.ball_y, 235);
        tick();
        chk("move1_x", bus_r.ball_x, 316);
        chk("move1_y", bus_r.ball_y, 236);

        // Overlapping left paddle while moving right: no bounce
        bus_r.pad1_t = 10'd0; bus_r.pad1_b = 10'd479;
        bus_r.pad1_l = 10'd310; bus_r.pad1_r = 10'd320;
        tick();
        chk("nobounce_x", bus_r.ball_x, 317);
        chk("nobounce_dir", dut.dir_x, 1);

        // Paddles one ball-width apart: every frame is a hit, x holds at 317
        set_pads(307, 316, 327, 336);
        tick();
        chk("hit1_x", bus_r.ball_x, 317);
        chk("hit1_dir", dut.dir_x, 0);
        chk("hit1_cnt", dut.hit_cnt, 1);
        chk("hit1_y", bus_r.ball_y, 238);
        ticks(3);
        chk("hit4_speed", dut.speed, 2);
        chk("hit4_cnt", dut.hit_cnt, 0);
        chk("hit4_y", bus_r.ball_y, 241);
        ticks(8);
        chk("hit12_speed", dut.speed, 4);
        ticks(4);
        chk("hit16_speed", dut.speed, 4);
        chk("hit16_cnt", dut.hit_cnt, 0);
        chk("hit16_y", bus_r.ball_y, 277);
        chk("hit16_dir", dut.dir_x, 1);

        // Bottom wall together with a paddle hit
        ticks(48);
        chk("pre_bot_y", bus_r.ball_y, 469);
        tick();
        chk("bot_y", bus_r.ball_y, 470);
        chk("bot_dir_y", dut.dir_y, 0);
        chk("bot_x", bus_r.ball_x, 317);

        // Top wall clamp from y=2 at speed 4
        ticks(117);
        chk("pre_top_y", bus_r.ball_y, 2);
        chk("pre_top_dir_y", dut.dir_y, 0);
        tick();
        chk("top_y", bus_r.ball_y, 0);
        chk("top_dir_y", dut.dir_y, 1);
        chk("top_dir_x", dut.dir_x, 0);

        // Run off the left edge
        park();
        ticks(79);
        chk("edge_x", bus_r.ball_x, 1);
        chk("edge_y", bus_r.ball_y, 316);
        tick();
        chk("score2_pulse", bus_r.score2, 1);
        chk("score1_quiet", bus_r.score1, 0);
        chk("scored_serving", bus_r.serving, 0);
        chk("scored_x_held", bus_r.ball_x, 1);
        @(negedge clk);
        chk("score2_one_clk", bus_r.score2, 0);
        tick();
        chk("reserve_serving", bus_r.serving, 1);
        chk("reserve_x", bus_r.ball_x, 315);
        chk("reserve_y", bus_r.ball_y, 235);
        chk("reserve_dir_x", dut.dir_x, 0);
        chk("reserve_dir_y", dut.dir_y, 0);
        chk("reserve_speed", dut.speed, 1);
        chk("reserve_cnt", dut.hit_cnt, 0);

        // Second rally to speed 3, then reset mid-flight
        ticks(60);
        chk("serve2_serving", bus_r.serving, 0);
        set_pads(305, 314, 325, 334);
        ticks(8);
        chk("rally2_speed", dut.speed, 3);
        chk("rally2_x", bus_r.ball_x, 315);
        chk("rally2_y", bus_r.ball_y, 223);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_serving", bus_r.serving, 1);
        chk("midrst_x", bus_r.ball_x, 315);
        chk("midrst_y", bus_r.ball_y, 235);
        chk("midrst_speed", dut.speed, 1);
        chk("midrst_dir_x", dut.dir_x, 1);
        chk("midrst_score1", bus_r.score1, 0);
        chk("midrst_score2", bus_r.score2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
